// File: rtl/reaction_pkg.sv
// Shared types and constants for the two-player reaction match referee.
package reaction_pkg;

  typedef enum logic [2:0] {
    ARM,
    WAIT,
    GO,
    RESULT,
    MATCH_OVER
  } match_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          SCORE_W   = 4;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] limit);
    return (s >= limit) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/reaction_match_ctrl_lfsr16.sv
// 16-bit Galois LFSR used to randomise the pre-start delay.
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Non-zero seed plus a maximal-length polynomial keeps the state away from zero
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_match_ctrl.sv
// Reaction-game match referee: random pre-start delay, false-start detection,
// round winner/tie/timeout decisions and per-player scoring up to a target score.
module reaction_match_ctrl
  import reaction_pkg::*;
#(
  parameter int CLOCK_FREQ    = 1,
  parameter int MIN_DELAY     = 2 * CLOCK_FREQ,
  parameter int RAND_BITS     = 3,
  parameter int REACT_TIMEOUT = 5 * CLOCK_FREQ,
  parameter int RESULT_HOLD   = 3 * CLOCK_FREQ,
  parameter int WIN_SCORE     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn1,
  input  logic               btn2,
  input  logic               new_match,
  output logic               start_led,
  output logic               win1_led,
  output logic               win2_led,
  output logic               foul1_led,
  output logic               foul2_led,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               match_over
);

  localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_BITS)) + 1;
  localparam int RSP_W = $clog2(REACT_TIMEOUT) + 1;
  localparam int HLD_W = $clog2(RESULT_HOLD) + 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  match_state_t       state_q;
  logic [DLY_W-1:0]   delay_cnt_q;
  logic [RSP_W-1:0]   resp_cnt_q;
  logic [HLD_W-1:0]   hold_cnt_q;
  logic               btn1_prev_q, btn2_prev_q;
  logic               start_q, win1_q, win2_q, foul1_q, foul2_q, over_q;
  logic [SCORE_W-1:0] score1_q, score2_q;

  logic [15:0] lfsr_val;
  logic        lfsr_unused;
  logic        press1, press2;

  lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (1'b1),
    .lfsr_o (lfsr_val)
  );

  // Only the low RAND_BITS of the LFSR feed the delay
  assign lfsr_unused = ^lfsr_val;

  // Rising edges only: a level held across rounds or through reset never scores
  assign press1 = btn1 & ~btn1_prev_q;
  assign press2 = btn2 & ~btn2_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARM;
      delay_cnt_q <= '0;
      resp_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      btn1_prev_q <= 1'b1;
      btn2_prev_q <= 1'b1;
      start_q     <= 1'b0;
      win1_q      <= 1'b0;
      win2_q      <= 1'b0;
      foul1_q     <= 1'b0;
      foul2_q     <= 1'b0;
      over_q      <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
    end else begin
      btn1_prev_q <= btn1;
      btn2_prev_q <= btn2;
      case (state_q)
        ARM: begin
          delay_cnt_q <= DLY_W'(MIN_DELAY) + DLY_W'(lfsr_val[RAND_BITS-1:0]);
          start_q     <= 1'b0;
          win1_q      <= 1'b0;
          win2_q      <= 1'b0;
          foul1_q     <= 1'b0;
          foul2_q     <= 1'b0;
          state_q     <= WAIT;
        end

        WAIT: begin
          // Presses are checked before the count so a press on the last WAIT cycle is a foul
          if (press1 && press2) begin
            foul1_q    <= 1'b1;
            foul2_q    <= 1'b1;
            hold_cnt_q <= HLD_W'(RESULT_HOLD);
            state_q    <= RESULT;
          end else if (press1) begin
            foul1_q    <= 1'b1;
            score2_q   <= sat_inc(score2_q, WIN);
            hold_cnt_q <= HLD_W'(RESULT_HOLD);
            state_q    <= RESULT;
          end else if (press2) begin
            foul2_q    <= 1'b1;
            score1_q   <= sat_inc(score1_q, WIN);
            hold_cnt_q <= HLD_W'(RESULT_HOLD);
            state_q    <= RESULT;
          end else if (delay_cnt_q == DLY_W'(1)) begin
            start_q    <= 1'b1;
            resp_cnt_q <= '0;
            state_q    <= GO;
          end else begin
            delay_cnt_q <= delay_cnt_q - DLY_W'(1);
          end
        end

        GO: begin
          if (press1 || press2) begin
            start_q    <= 1'b0;
            win1_q     <= press1;
            win2_q     <= press2;
            if (press1 && !press2) begin
              score1_q <= sat_inc(score1_q, WIN);
            end else if (press2 && !press1) begin
              score2_q <= sat_inc(score2_q, WIN);
            end
            hold_cnt_q <= HLD_W'(RESULT_HOLD);
            state_q    <= RESULT;
          end else if (resp_cnt_q == RSP_W'(REACT_TIMEOUT - 1)) begin
            start_q    <= 1'b0;
            hold_cnt_q <= HLD_W'(RESULT_HOLD);
            state_q    <= RESULT;
          end else begin
            resp_cnt_q <= resp_cnt_q + RSP_W'(1);
          end
        end

        RESULT: begin
          if (hold_cnt_q == HLD_W'(1)) begin
            foul1_q <= 1'b0;
            foul2_q <= 1'b0;
            if (score1_q == WIN || score2_q == WIN) begin
              win1_q  <= (score1_q == WIN);
              win2_q  <= (score2_q == WIN);
              over_q  <= 1'b1;
              state_q <= MATCH_OVER;
            end else begin
              win1_q  <= 1'b0;
              win2_q  <= 1'b0;
              state_q <= ARM;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - HLD_W'(1);
          end
        end

        MATCH_OVER: begin
          if (new_match) begin
            score1_q <= '0;
            score2_q <= '0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            over_q   <= 1'b0;
            state_q  <= ARM;
          end
        end

        default: state_q <= ARM;
      endcase
    end
  end

  assign start_led  = start_q;
  assign win1_led   = win1_q;
  assign win2_led   = win2_q;
  assign foul1_led  = foul1_q;
  assign foul2_led  = foul2_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign match_over = over_q;

endmodule

// File: doc/reaction_match_ctrl.md
Name: reaction_match_ctrl

Overview:
Match referee for the two-player reaction game. It sequences rounds with a pseudo-random pre-start delay, detects false starts, and decides each round's winner, tie or timeout. It keeps per-player scores and ends the match at a target score. It sits between the debounced button inputs and the LED/score display, and replaces the fixed-period auto-restart round loop.

Parameters:
CLOCK_FREQ, 1, clock ticks per second; all times below are in seconds multiplied by this.
MIN_DELAY, 2*CLOCK_FREQ, minimum cycles spent in WAIT before the start light.
RAND_BITS, 3, number of LFSR bits added to MIN_DELAY; added range is 0..2^RAND_BITS-1 cycles.
REACT_TIMEOUT, 5*CLOCK_FREQ, cycles in GO with no press before the round is void.
RESULT_HOLD, 3*CLOCK_FREQ, cycles the round result is displayed.
WIN_SCORE, 5, points needed to win the match (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn1  in  1  player 1 button, already synchronised and debounced, level
btn2  in  1  player 2 button, already synchronised and debounced, level
new_match  in  1  single-cycle pulse; leaves MATCH_OVER and clears scores
start_led  out  1  high during GO only
win1_led  out  1  player 1 won the round, or won the match
win2_led  out  1  player 2 won the round, or won the match
foul1_led  out  1  player 1 false start (in RESULT)
foul2_led  out  1  player 2 false start (in RESULT)
score1  out  4  player 1 points
score2  out  4  player 2 points
match_over  out  1  high in MATCH_OVER

Behaviour:
- Reset: synchronous, active-high, sampled at posedge clk, priority over everything.
  - All outputs go to 0; scores go to 0; state goes to ARM.
  - LFSR loads 16'hACE1.
  - Button history registers load 1, so a button held through reset is not a press.
- Press detection: press_n = btn_n & ~btn_prev_n, registered every cycle. Only presses count, never levels.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle except during reset. Never reaches zero.
- States: ARM, WAIT, GO, RESULT, MATCH_OVER.
- ARM (1 cycle):
  - Load delay_cnt = MIN_DELAY + lfsr[RAND_BITS-1:0].
  - Clear all round LEDs.
  - Go to WAIT.
- WAIT:
  - delay_cnt decrements each cycle; on reaching 1, go to GO next cycle with start_led=1.
  - Press by player n: foul_n=1, opponent score +1, go to RESULT.
  - Both press in the same cycle: both foul LEDs set, no score change, go to RESULT.
- GO:
  - resp_cnt counts from 0.
  - Single press by player n in cycle k: win_n=1 and start_led=0 at the same edge the press is sampled. score_n +1. Go to RESULT.
  - Both press in the same cycle: tie; win1 and win2 both 1, no score change, go to RESULT.
  - resp_cnt reaches REACT_TIMEOUT-1 with no press: all LEDs 0, no score change, go to RESULT.
- RESULT:
  - Holds the LEDs for RESULT_HOLD cycles; presses are ignored.
  - Then, if either score equals WIN_SCORE, go to MATCH_OVER; else go to ARM.
- MATCH_OVER:
  - match_over=1; the winner's win LED is on; scores are frozen; buttons are ignored.
  - new_match: scores go to 0, go to ARM.
  - new_match in any other state is ignored.
- Scores saturate at WIN_SCORE and never wrap. The score update and the result LEDs commit on the same edge.
- A press sampled on the same edge as the WAIT→GO transition counts as a false start.
- A press on the last GO cycle beats the timeout.

Decomposition:
- Package reaction_pkg:
  - state enum match_state_t {ARM, WAIT, GO, RESULT, MATCH_OVER}.
  - LFSR_SEED, LFSR_TAPS.
  - Score width constant SCORE_W=4.
- One sub-module, lfsr16: outputs the LFSR value, with clk, reset and enable inputs.
- The FSM, counters and scoring stay in reaction_match_ctrl.

Test Plan:
Bench parameters: CLOCK_FREQ=1, MIN_DELAY=4, RAND_BITS=2, REACT_TIMEOUT=8, RESULT_HOLD=3, WIN_SCORE=3.
- Reset, no presses → start_led rises 5..8 cycles after reset release. After 8 GO cycles start_led falls, no LEDs for 3 cycles, score1=score2=0, start_led rises again.
- btn1 pressed 2 cycles after start_led rises → win1_led=1 and start_led=0 on that edge; score1=1; win1_led held 3 cycles then cleared in ARM.
- btn2 pressed during WAIT → foul2_led=1, score1=1, start_led never rises in that round. Repeat with both pressed in the same cycle → both fouls, scores unchanged.
- btn1 and btn2 pressed in the same GO cycle → win1_led=win2_led=1, scores unchanged. btn1 held high across the next round → no press counted.
- Player 2 wins 3 rounds → after the third RESULT, match_over=1, score2=3, win2_led=1. Presses are ignored. new_match pulse → scores 0, next round starts.
- Assert reset mid-GO while score1=2 → next edge: all outputs 0, scores 0, state ARM. A button held during reset does not register.
